// File: rtl/sha3_pkg.sv
// Shared constants, squeeze FSM state encoding and the lane-extract helper
// for the SHA-3 squeeze stage. The PERM state only exists when
// SHA3_SQUEEZE_XOF_EN is defined.
package sha3_pkg;

   localparam int STATE_W       = 1600;
   localparam int LANE_W        = 64;
   localparam int NUM_LANES     = 25;
   localparam int LANE_IDX_W    = 5;

   localparam int RATE_SHA3_256 = 17;
   localparam int RATE_SHAKE256 = 17;
   localparam int RATE_SHAKE128 = 21;
   localparam int RATE_SHA3_512 = 9;

   typedef enum logic [1:0] {
      SQ_IDLE    = 2'd0,
      SQ_WAIT_ST = 2'd1,
`ifdef SHA3_SQUEEZE_XOF_EN
      SQ_EMIT    = 2'd2,
      SQ_PERM    = 2'd3
`else
      SQ_EMIT    = 2'd2
`endif
   } sq_state_t;

   // Lane l occupies state bits l*64+k; bit k of the result is state bit l*64+k.
   function automatic logic [LANE_W-1:0] lane_extract(input logic [0:STATE_W-1] st,
                                                      input logic [LANE_IDX_W-1:0] l);
      logic [LANE_W-1:0] lane;
      logic [10:0]       w_idx;
      lane = {LANE_W{1'b0}};
      for (int k = 0; k < LANE_W; k++) begin
         w_idx   = 11'(int'(l) * LANE_W + k);
         lane[k] = st[w_idx];
      end
      return lane;
   endfunction

endpackage

// File: rtl/sha3_lane_mux.sv
// Combinational RATE_LANES:1 selector of one 64-bit lane from the snapshot.
// An out-of-range select yields zero.
module sha3_lane_mux
   import sha3_pkg::*;
#(
   parameter int RATE_LANES = 17
) (
   input  logic [LANE_W-1:0]     i_lanes [RATE_LANES],
   input  logic [LANE_IDX_W-1:0] i_sel,
   output logic [LANE_W-1:0]     o_data
);

   // AND-OR selection across all rate lanes.
   always_comb begin
      o_data = {LANE_W{1'b0}};
      for (int j = 0; j < RATE_LANES; j++) begin
         o_data = o_data | ({LANE_W{i_sel == LANE_IDX_W'(j)}} & i_lanes[j]);
      end
   end

endmodule

// File: rtl/sha3_squeezer.sv
// Squeeze stage of the SHA-3/SHAKE sponge: snapshots the rate lanes of a
// finished permutation and streams them out as 64-bit words over valid/ready.
// Build option SHA3_SQUEEZE_XOF_EN: when defined, output length is unbounded
// and a permutation is requested each time the rate is exhausted; otherwise
// the length is clamped to RATE_LANES words and perm_req_o is tied low.
module sha3_squeezer
   import sha3_pkg::*;
#(
   parameter int RATE_LANES = 17,
   parameter int LEN_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [LEN_W-1:0]   len_i,
   input  logic [0:STATE_W-1] state_i,
   input  logic               state_valid_i,
   output logic               perm_req_o,
   output logic [LANE_W-1:0]  data_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic               last_o,
   output logic               busy_o,
   output logic               done_o
);

   sq_state_t             r_state;
   logic [LEN_W-1:0]      r_remaining;
   logic [LANE_IDX_W-1:0] r_lane;
   logic [LANE_W-1:0]     r_snap [RATE_LANES];
   logic [LANE_W-1:0]     r_data;
   logic                  r_valid;
   logic                  r_last;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_perm_req;

   logic                  w_xfer;
   logic [LANE_IDX_W-1:0] w_next_lane;
   logic [LANE_W-1:0]     w_mux_data;
   logic [LEN_W-1:0]      w_start_len;
   logic                  w_unused_st;

   assign w_xfer      = r_valid & ready_i;
   assign w_next_lane = r_lane + 5'd1;
   // Capacity lanes never reach the snapshot.
   assign w_unused_st = ^state_i;

`ifdef SHA3_SQUEEZE_XOF_EN
   assign w_start_len = len_i;
`else
   assign w_start_len = (len_i > LEN_W'(RATE_LANES)) ? LEN_W'(RATE_LANES) : len_i;
`endif

   sha3_lane_mux #(.RATE_LANES(RATE_LANES)) u_lane_mux (
      .i_lanes (r_snap),
      .i_sel   (w_next_lane),
      .o_data  (w_mux_data)
   );

   // Snapshot the rate lanes when a finished permutation arrives while waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < RATE_LANES; j++) r_snap[j] <= {LANE_W{1'b0}};
      end else if ((r_state == SQ_WAIT_ST) && state_valid_i) begin
         for (int j = 0; j < RATE_LANES; j++) r_snap[j] <= lane_extract(state_i, LANE_IDX_W'(j));
      end else begin
         for (int j = 0; j < RATE_LANES; j++) r_snap[j] <= r_snap[j];
      end
   end

   // Squeeze FSM with counters and the registered output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= SQ_IDLE;
         r_remaining <= {LEN_W{1'b0}};
         r_lane      <= {LANE_IDX_W{1'b0}};
         r_data      <= {LANE_W{1'b0}};
         r_valid     <= 1'b0;
         r_last      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_perm_req  <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_perm_req <= 1'b0;
         case (r_state)
            SQ_IDLE: begin
               if (start_i) begin
                  if (w_start_len == {LEN_W{1'b0}}) begin
                     r_done <= 1'b1;
                  end else begin
                     r_remaining <= w_start_len;
                     r_lane      <= {LANE_IDX_W{1'b0}};
                     r_busy      <= 1'b1;
                     r_state     <= SQ_WAIT_ST;
                  end
               end
            end
            SQ_WAIT_ST: begin
               if (state_valid_i) begin
                  // Lane 0 comes straight from the input so valid rises next cycle.
                  r_data  <= lane_extract(state_i, {LANE_IDX_W{1'b0}});
                  r_last  <= (r_remaining == LEN_W'(1));
                  r_valid <= 1'b1;
                  r_state <= SQ_EMIT;
               end
            end
            SQ_EMIT: begin
               if (w_xfer) begin
                  if (r_remaining != {LEN_W{1'b0}}) r_remaining <= r_remaining - LEN_W'(1);
                  if (r_remaining == LEN_W'(1)) begin
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_lane  <= {LANE_IDX_W{1'b0}};
                     r_state <= SQ_IDLE;
`ifdef SHA3_SQUEEZE_XOF_EN
                  end else if (r_lane == LANE_IDX_W'(RATE_LANES - 1)) begin
                     r_valid    <= 1'b0;
                     r_last     <= 1'b0;
                     r_lane     <= {LANE_IDX_W{1'b0}};
                     r_perm_req <= 1'b1;
                     r_state    <= SQ_PERM;
`endif
                  end else begin
                     r_lane <= w_next_lane;
                     r_data <= w_mux_data;
                     r_last <= (r_remaining == LEN_W'(2));
                  end
               end
            end
`ifdef SHA3_SQUEEZE_XOF_EN
            SQ_PERM: begin
               r_state <= SQ_WAIT_ST;
            end
`endif
            default: begin
               r_state <= SQ_IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign perm_req_o = r_perm_req;
   assign data_o     = r_data;
   assign valid_o    = r_valid;
   assign last_o     = r_last;
   assign busy_o     = r_busy;
   assign done_o     = r_done;

endmodule

// File: tb/tb_sha3_squeezer.sv
// Self-checking bench for sha3_squeezer. The reference model is the word
// sequence itself: word i of a squeeze is lane (i mod RATE) of permutation
// block (i div RATE), truncated to RATE words unless SHA3_SQUEEZE_XOF_EN.
module tb_sha3_squeezer;

   localparam int RATE = 17;
   localparam int LW   = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              start_i;
   logic [LW-1:0]     len_i;
   logic [0:1599]     state_i;
   logic              state_valid_i;
   logic              perm_req_o;
   logic [63:0]       data_o;
   logic              valid_o;
   logic              ready_i;
   logic              last_o;
   logic              busy_o;
   logic              done_o;

   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] blk [8][25];

   sha3_squeezer #(.RATE_LANES(RATE), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i), .state_i(state_i),
      .state_valid_i(state_valid_i), .perm_req_o(perm_req_o), .data_o(data_o),
      .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o), .busy_o(busy_o),
      .done_o(done_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // mode 0: block b lane l = b*0x100 + l ; mode 1: random lanes
   task automatic fill(input int mode);
      for (int b = 0; b < 8; b++)
         for (int l = 0; l < 25; l++)
            blk[b][l] = (mode == 0) ? 64'(b * 256 + l) : {$urandom, $urandom};
   endtask

   function automatic logic [0:1599] pack(input int b);
      logic [0:1599] s;
      for (int l = 0; l < 25; l++)
         for (int k = 0; k < 64; k++)
            s[l * 64 + k] = blk[b][l][k];
      return s;
   endfunction

   // rmode: 0 ready high, 1 toggling, 2 random
   task automatic run(input int len, input int rmode, input int inj_start,
                      input int abort_after, input string nm);
      int exp_len, exp_perm;
      int n_words = 0, n_perm = 0, sv_cnt, sv_blk = 0, cyc = 0, first_v = -1, last_x = 0;
      logic seen_valid = 1'b0, seen_busy = 1'b0, got_done = 1'b0, prev_stall = 1'b0, injected = 1'b0;
      logic [63:0] prev_data = 64'd0;
      logic prev_last = 1'b0;
`ifdef SHA3_SQUEEZE_XOF_EN
      exp_len  = len;
      exp_perm = (exp_len > 0) ? (exp_len - 1) / RATE : 0;
`else
      exp_len  = (len > RATE) ? RATE : len;
      exp_perm = 0;
`endif
      @(negedge clk);
      start_i = 1'b1;
      len_i   = LW'(len);
      ready_i = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      sv_cnt  = $urandom_range(1, 3);
      while (!got_done && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         start_i       = 1'b0;
         state_valid_i = 1'b0;
         if (abort_after > 0 && n_words == abort_after) begin
            rst = 1'b1;
            @(negedge clk);
            check({nm, " rst valid"}, 64'(valid_o), 64'd0);
            check({nm, " rst busy"},  64'(busy_o),  64'd0);
            check({nm, " rst last"},  64'(last_o),  64'd0);
            rst = 1'b0;
            return;
         end
         if (prev_stall) begin
            check({nm, " stall data"}, data_o, prev_data);
            check({nm, " stall last"}, 64'(last_o), 64'(prev_last));
         end
         if (valid_o) begin
            seen_valid = 1'b1;
            if (first_v < 0) first_v = cyc;
         end
         if (busy_o) seen_busy = 1'b1;
         if (perm_req_o) n_perm++;
         if (done_o) got_done = 1'b1;
         if (sv_cnt > 0) begin
            sv_cnt--;
            if (sv_cnt == 0) begin
               state_valid_i = 1'b1;
               state_i       = pack(sv_blk);
               sv_blk++;
            end
         end
         if (perm_req_o) sv_cnt = $urandom_range(1, 3);
         case (rmode)
            0:       ready_i = 1'b1;
            1:       ready_i = ~ready_i;
            default: ready_i = 1'($urandom_range(0, 1));
         endcase
         if (inj_start != 0 && !injected && n_words == 1 && valid_o) begin
            start_i  = 1'b1;
            len_i    = LW'(9);
            injected = 1'b1;
         end
         if (valid_o && ready_i) begin
            if (n_words < exp_len) begin
               check({nm, " data"}, data_o, blk[n_words / RATE][n_words % RATE]);
               check({nm, " last"}, 64'(last_o), 64'(n_words == exp_len - 1));
            end else begin
               check({nm, " extra word"}, 64'd1, 64'd0);
            end
            n_words++;
            last_x = cyc;
         end
         prev_stall = valid_o && !ready_i;
         prev_data  = data_o;
         prev_last  = last_o;
      end
      check({nm, " done seen"}, 64'(got_done), 64'd1);
      check({nm, " word count"}, 64'(n_words), 64'(exp_len));
      check({nm, " perm count"}, 64'(n_perm), 64'(exp_perm));
      check({nm, " busy at done"}, 64'(busy_o), 64'd0);
      check({nm, " valid at done"}, 64'(valid_o), 64'd0);
      check({nm, " valid seen"}, 64'(seen_valid), 64'(exp_len > 0));
      check({nm, " busy seen"}, 64'(seen_busy), 64'(exp_len > 0));
      if (rmode == 0 && n_perm == 0 && exp_len > 0)
         check({nm, " back-to-back"}, 64'(last_x - first_v + 1), 64'(exp_len));
      @(negedge clk);
      check({nm, " done pulse"}, 64'(done_o), 64'd0);
   endtask

   initial begin
      rst           = 1'b1;
      start_i       = 1'b0;
      len_i         = '0;
      state_i       = '0;
      state_valid_i = 1'b0;
      ready_i       = 1'b0;
      repeat (3) @(negedge clk);
      check("reset valid", 64'(valid_o), 64'd0);
      check("reset busy",  64'(busy_o),  64'd0);
      check("reset done",  64'(done_o),  64'd0);
      check("reset last",  64'(last_o),  64'd0);
      check("reset perm",  64'(perm_req_o), 64'd0);
      check("reset data",  data_o, 64'd0);
      rst = 1'b0;

      fill(0);
      run(4, 0, 0, 0, "t1 len4");
      run(4, 1, 0, 0, "t2 toggle");
      run(0, 0, 0, 0, "t3 len0");
      run(20, 0, 0, 0, "t4 len20");
      run(4, 0, 0, 2, "t5 abort");
      run(3, 0, 0, 0, "t5 restart");
      run(5, 1, 1, 0, "t6 inject");
      run(RATE, 0, 0, 0, "rate boundary");
      run(1, 2, 0, 0, "len1");

      for (int t = 0; t < 12; t++) begin
         fill(1);
         run($urandom_range(0, 60), $urandom_range(0, 2), 0, 0, $sformatf("rand%0d", t));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
